bf_uart_bridge: RTL and testbench

- Buffered, bidirectional byte bridge between the BF core's stdout/stdin ports and the board UART pins.
- Replaces the current stall-per-byte scheme, where the CPU halts while the transmitter is busy, with parametrised TX/RX FIFOs and a valid/ready handshake on each direction.
- Adds a UART receiver so the `,` instruction can read host input.
- Sits in the top level between proc and the uart pins, clocked by the system clock.

---
 rtl/bf_uart_bridge.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_bf_uart_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_uart_bridge.sv
`default_nettype none
// -----------------------------------------------------------------------------
// bf_uart_bridge: BF core stdout/stdin <-> 8N1 UART pins through TX/RX FIFOs
// Rev 1.0
// -----------------------------------------------------------------------------

module bf_uart_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                push,
  input  logic [7:0]          push_data,
  input  logic                pop,
  output logic [7:0]          head,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty
);
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [7:0]          mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    full     = (level == DEPTH);
    empty    = (level == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + ONE : rd_ptr_q;
    head     = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
    end
  end
endmodule

module bf_uart_bridge #(
  parameter int CLK_DIV       = 104,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             stdout_data,
  input  logic                   stdout_valid,
  output logic                   stdout_ready,
  output logic [7:0]             stdin_data,
  output logic                   stdin_valid,
  input  logic                   stdin_ready,
  output logic [TX_DEPTH_LOG2:0] tx_level,
  output logic [RX_DEPTH_LOG2:0] rx_level,
  output logic                   rx_frame_err,
  output logic                   rx_overrun,
  output logic                   uart_tx_pin,
  input  logic                   uart_rx_pin
);
  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3
  } tx_state_t;
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3
  } rx_state_t;

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_pin_q, tx_pin_d;
  logic          tx_pop, tx_full, tx_empty, tx_bit_end;
  logic [7:0]    tx_head;

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          sync1_q, sync2_q, rx_prev_q;
  logic          rx_frame_err_q, rx_frame_err_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          rx_push, rx_full, rx_empty, rx_bit_end;
  logic [7:0]    rx_head;

  bf_uart_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (stdout_valid),
    .push_data (stdout_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .level     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  bf_uart_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (rx_push),
    .push_data (rx_shift_q),
    .pop       (stdin_ready),
    .head      (rx_head),
    .level     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign stdout_ready = !tx_full;
  assign stdin_valid  = !rx_empty;
  assign stdin_data   = rx_empty ? 8'h00 : rx_head;
  assign uart_tx_pin  = tx_pin_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun   = rx_overrun_q;

  // The pin is registered from the current state, so it trails the FSM by one
  // cycle: push at edge N, pop at N+1, start bit on the pin from N+2.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == BIT_LAST);
    tx_pin_d   = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_pin_d = 1'b0;
        tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_pin_d = tx_shift_q[0];
        tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_pin_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_pin_q   <= tx_pin_d;
    end
  end

  // Receiver works on sync2_q only; rx_prev_q gives the falling-edge detect.
  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_push        = 1'b0;
    rx_frame_err_d = 1'b0;
    rx_overrun_d   = 1'b0;
    rx_bit_end     = (rx_cnt_q == BIT_LAST);
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !sync2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
        if (rx_bit_end) begin
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
        if (rx_bit_end) begin
          rx_state_d = RX_IDLE;
          if (!sync2_q) begin
            rx_frame_err_d = 1'b1;
          end else if (rx_full) begin
            rx_overrun_d = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;
    end else begin
      sync1_q        <= uart_rx_pin;
      sync2_q        <= sync1_q;
      rx_prev_q      <= sync2_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_overrun_q   <= rx_overrun_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bf_uart_bridge.sv
`default_nettype none
// Bench for bf_uart_bridge: directed and random traffic, queue scoreboards on
// the serial TX output and the stdin handshake.
module tb_bf_uart_bridge;
  localparam int CLK_DIV  = 4;
  localparam int TXL      = 2;
  localparam int RXL      = 4;
  localparam int RX_DEPTH = 16;
  localparam int FRAME    = 10 * CLK_DIV;

  logic           clk = 1'b0;
  logic           rstn;
  logic [7:0]     stdout_data;
  logic           stdout_valid;
  logic           stdout_ready;
  logic [7:0]     stdin_data;
  logic           stdin_valid;
  logic           stdin_ready;
  logic [TXL:0]   tx_level;
  logic [RXL:0]   rx_level;
  logic           rx_frame_err;
  logic           rx_overrun;
  logic           uart_tx_pin;
  logic           uart_rx_pin;

  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  int             rdy_mode = 0;
  int             ferr_cnt = 0, ovr_cnt = 0;
  int             exp_ferr = 0, exp_ovr = 0;
  logic [7:0]     tx_exp[$];
  int             tx_starts[$];
  logic [7:0]     rx_exp[$];

  bf_uart_bridge #(.CLK_DIV(CLK_DIV), .TX_DEPTH_LOG2(TXL), .RX_DEPTH_LOG2(RXL)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stdout_data  (stdout_data),
    .stdout_valid (stdout_valid),
    .stdout_ready (stdout_ready),
    .stdin_data   (stdin_data),
    .stdin_valid  (stdin_valid),
    .stdin_ready  (stdin_ready),
    .tx_level     (tx_level),
    .rx_level     (rx_level),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .uart_tx_pin  (uart_tx_pin),
    .uart_rx_pin  (uart_rx_pin)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // stdin_ready changes just after the rising edge so monitors see it settled.
  initial begin : rdy_drv
    stdin_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       stdin_ready = 1'b0;
        1:       stdin_ready = 1'($urandom_range(0, 1));
        default: stdin_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) ferr_cnt++;
    if (rx_overrun === 1'b1) ovr_cnt++;
  end

  // stdin scoreboard: each handshake must deliver the oldest expected byte.
  always @(negedge clk) begin
    if (rstn === 1'b1 && stdin_valid === 1'b1 && stdin_ready === 1'b1) begin
      if (rx_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected_byte actual=%02h required=none", stdin_data);
      end else begin
        check("rx_data", stdin_data, rx_exp.pop_front());
      end
    end
  end

  // Serial decoder: start found at a sample, bits taken at their mid-points.
  initial begin : tx_monitor
    logic [9:0] bits;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && uart_tx_pin === 1'b0) begin
        tx_starts.push_back(cyc);
        aborted = 1'b0;
        bits    = '0;
        for (int i = 0; i < 10 && !aborted; i++) begin
          for (int k = 0; k < ((i == 0) ? CLK_DIV / 2 : CLK_DIV); k++) begin
            @(negedge clk);
            if (rstn !== 1'b1) aborted = 1'b1;
          end
          bits[i] = uart_tx_pin;
        end
        if (!aborted) begin
          check("tx_framing", {30'd0, bits[9], bits[0]}, 32'h2);
          if (tx_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected_frame actual=%02h required=none", bits[8:1]);
          end else begin
            check("tx_data", bits[8:1], tx_exp.pop_front());
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output int edge_idx);
    int guard = 0;
    @(negedge clk);
    while (!stdout_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    stdout_valid = 1'b1;
    stdout_data  = b;
    tx_exp.push_back(b);
    edge_idx = cyc + 1;
    @(negedge clk);
    stdout_valid = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int guard = 0;
    while ((tx_exp.size() != 0 || tx_level != 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    check("tx_drain", tx_exp.size(), 0);
  endtask

  // Reference: good frames land in order unless 16 are already waiting.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    if (!stop_bit) exp_ferr++;
    else if (rx_exp.size() == RX_DEPTH) exp_ovr++;
    else rx_exp.push_back(b);
    for (int i = 0; i < 10; i++) begin
      uart_rx_pin = bits[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx_pin = 1'b1;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic drain_rx();
    int guard = 0;
    rdy_mode = 2;
    while (rx_exp.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("rx_drain", rx_exp.size(), 0);
    check("rx_level_drained", rx_level, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         n_edge, idx, guard, stall_at, stall_level;
    logic [7:0] burst[6];
    logic       sb;

    rstn = 1'b0; stdout_valid = 1'b0; stdout_data = 8'h00; uart_rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_pin", uart_tx_pin, 1);
    check("rst_stdout_ready", stdout_ready, 1);
    check("rst_stdin_valid", stdin_valid, 0);
    check("rst_stdin_data", stdin_data, 0);
    check("rst_levels", {tx_level, rx_level}, 0);
    check("rst_err_pulses", {rx_frame_err, rx_overrun}, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame of zeros must free the line immediately.
    push_byte(8'h00, n_edge);
    repeat (8) @(negedge clk);
    check("tx_pin_midframe", uart_tx_pin, 0);
    #2 rstn = 1'b0;
    #1 check("tx_pin_async_reset", uart_tx_pin, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tx_exp.delete();
    @(negedge clk);
    check("post_rst_ready", stdout_ready, 1);
    check("post_rst_levels", {tx_level, rx_level}, 0);
    check("post_rst_stdin_valid", stdin_valid, 0);
    check("post_rst_tx_pin", uart_tx_pin, 1);
    repeat (FRAME) @(negedge clk);

    // Single byte: start bit two edges after the push edge.
    tx_starts.delete();
    push_byte(8'hA5, n_edge);
    guard = 0;
    while (tx_starts.size() == 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("tx_start_latency", (tx_starts.size() > 0) ? tx_starts[0] : -1, n_edge + 2);
    wait_tx_drain();
    check("tx_level_idle", tx_level, 0);

    // Burst of 6 into a 4-deep FIFO.
    tx_starts.delete();
    foreach (burst[i]) burst[i] = 8'($urandom);
    idx = 0; guard = 0; stall_at = -1; stall_level = -1;
    @(negedge clk);
    while (idx < 6 && guard < 2000) begin
      stdout_valid = 1'b1;
      stdout_data  = burst[idx];
      if (stdout_ready) begin
        tx_exp.push_back(burst[idx]);
        idx++;
      end else if (stall_at < 0) begin
        stall_at    = idx;
        stall_level = int'(tx_level);
      end
      @(negedge clk);
      guard++;
    end
    stdout_valid = 1'b0;
    check("burst_accept_before_stall", stall_at, 5);
    check("burst_level_at_stall", stall_level, 4);
    wait_tx_drain();
    check("burst_frames", tx_starts.size(), 6);
    for (int i = 1; i < 6 && i < tx_starts.size(); i++)
      check("burst_frame_gap", tx_starts[i] - tx_starts[i-1], FRAME);

    // Random TX traffic with random valid gaps.
    idx = 0; guard = 0;
    while (idx < 12 && guard < 5000) begin
      stdout_valid = 1'($urandom_range(0, 1));
      stdout_data  = 8'($urandom);
      if (stdout_valid && stdout_ready) begin
        tx_exp.push_back(stdout_data);
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    stdout_valid = 1'b0;
    wait_tx_drain();

    // RX single frame held until consumed.
    send_frame(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    check("rx_valid", stdin_valid, 1);
    check("rx_level_one", rx_level, 1);
    check("rx_head", stdin_data, 8'h3C);
    repeat (5) @(negedge clk);
    check("rx_head_stable", stdin_data, 8'h3C);
    drain_rx();
    check("rx_valid_after_pop", stdin_valid, 0);

    // Bad stop bit.
    send_frame(8'h55, 1'b0);
    repeat (3) @(negedge clk);
    check("rx_frame_err_count", ferr_cnt, exp_ferr);
    check("rx_level_after_ferr", rx_level, 0);

    // Fill then overrun.
    for (int i = 0; i < RX_DEPTH; i++) send_frame(8'($urandom), 1'b1);
    repeat (3) @(negedge clk);
    check("rx_level_full", rx_level, RX_DEPTH);
    send_frame(8'($urandom), 1'b1);
    repeat (3) @(negedge clk);
    check("rx_overrun_count", ovr_cnt, exp_ovr);
    check("rx_level_after_ovr", rx_level, RX_DEPTH);
    drain_rx();

    // One-clock glitch is a false start.
    uart_rx_pin = 1'b0;
    @(negedge clk);
    uart_rx_pin = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    check("false_start_level", rx_level, 0);
    check("false_start_errs", ferr_cnt + ovr_cnt, exp_ferr + exp_ovr);
    send_frame(8'h81, 1'b1);
    repeat (3) @(negedge clk);
    check("after_false_start_level", rx_level, 1);
    drain_rx();

    // Random RX frames, occasional bad stop bit, random consumer.
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      sb = ($urandom_range(0, 3) != 0);
      send_frame(8'($urandom), sb);
    end
    drain_rx();
    check("rand_frame_err_count", ferr_cnt, exp_ferr);
    check("rand_overrun_count", ovr_cnt, exp_ovr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
